keypad_responder: RTL

KEYPAD_RESPONDER -- requirements
Module: keypad_responder

---
 rtl/keypad_responder_if.sv | 23 ++
 rtl/keypad_responder.sv | 125 ++++++++++++
 2 files changed

// File: rtl/keypad_responder_if.sv
// Keypad responder bundle: scanner strobe/row return plus the
// press-request handshake and status pulses.
interface keypad_responder_if;
  logic [2:0] key_col;
  logic [3:0] key_row;
  logic       req;
  logic [3:0] key_code;
  logic       ack;
  logic       err;
  logic       busy;
  logic       done;
  logic       hit;

  modport master (
    output key_col, req, key_code,
    input  key_row, ack, err, busy, done, hit
  );

  modport slave (
    input  key_col, req, key_code,
    output key_row, ack, err, busy, done, hit
  );
endinterface

// File: rtl/keypad_responder.sv
// Emulates one keypad key press/release against a column-strobing
// scanner: holds the row line for HOLD_CYCLES, then a quiet gap.
module keypad_responder #(
  parameter int HOLD_CYCLES    = 500000,
  parameter int RELEASE_CYCLES = 500000
) (
  input logic               clk,
  input logic               rst,
  keypad_responder_if.slave kp
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    RELEASE
  } state_t;

  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] REL_LAST  = 24'(RELEASE_CYCLES - 1);

  state_t      state;
  logic [23:0] cnt;
  logic [3:0]  code_q;
  logic [3:0]  row_q;
  logic        ack_q;
  logic        err_q;
  logic        busy_q;
  logic        done_q;
  logic        hit_q;

  function automatic logic [2:0] col_of(input logic [3:0] c);
    case (c)
      4'd1, 4'd4, 4'd7, 4'd10: col_of = 3'b001;
      4'd2, 4'd5, 4'd8, 4'd0:  col_of = 3'b010;
      4'd3, 4'd6, 4'd9, 4'd11: col_of = 3'b100;
      default:                 col_of = 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] row_of(input logic [3:0] c);
    case (c)
      4'd1, 4'd2, 4'd3:         row_of = 4'b0001;
      4'd4, 4'd5, 4'd6:         row_of = 4'b0010;
      4'd7, 4'd8, 4'd9:         row_of = 4'b0100;
      4'd10, 4'd0, 4'd11:       row_of = 4'b1000;
      default:                  row_of = 4'b0000;
    endcase
  endfunction

  // On the accept edge the code is not latched yet, so use the input.
  logic [3:0] sel_code;
  logic       legal;
  logic       match;
  logic [3:0] row_next;

  assign sel_code = (state == IDLE) ? kp.key_code : code_q;
  assign legal    = kp.key_code < 4'd12;
  assign match    = kp.key_col == col_of(sel_code);
  assign row_next = match ? row_of(sel_code) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      code_q <= '0;
      row_q  <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          row_q <= '0;
          if (kp.req && legal) begin
            state  <= PRESS;
            code_q <= kp.key_code;
            cnt    <= '0;
            ack_q  <= 1'b1;
            busy_q <= 1'b1;
            row_q  <= row_next;
            hit_q  <= match;
          end else if (kp.req) begin
            err_q <= 1'b1;
          end
        end
        PRESS: begin
          if (cnt == HOLD_LAST) begin
            state <= RELEASE;
            cnt   <= '0;
            row_q <= '0;
          end else begin
            cnt   <= cnt + 24'd1;
            row_q <= row_next;
            hit_q <= hit_q | match;
          end
        end
        RELEASE: begin
          row_q <= '0;
          if (cnt == REL_LAST) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign kp.key_row = row_q;
  assign kp.ack     = ack_q;
  assign kp.err     = err_q;
  assign kp.busy    = busy_q;
  assign kp.done    = done_q;
  assign kp.hit     = hit_q;

endmodule
